udc_8bit: RTL and testbench
===========================

// Module: udc_8bit
//
// PURPOSE
// - Loadable synchronous up/down counter, WIDTH bits wide (8 by default).
// - On each rising clock edge, exactly one action applies, in priority order:
//   reset, load a preset value, or count up/down by one.
// - Intended as a general-purpose counting/timing primitive inside larger
//   control datapaths.
// - Output is fully registered.
//
// PARAMETERS
// - WIDTH      8   counter/data width in bits; must be >= 1
// - RESET_VAL  0   value taken by out on reset; width WIDTH
//
// PORTS
// - clk     in   1      rising-edge clock; the only clock
// - resetn  in   1      synchronous, active-HIGH reset
//                       (the name follows codebase usage; the level is high)
// - in      in   WIDTH  parallel preset value, sampled when load=1
// - load    in   1      synchronous parallel load enable, active-high
// - ud      in   1      count direction: 1 = up (+1), 0 = down (-1)
// - out     out  WIDTH  current count, registered
//
// One clock; reset is synchronous and active-high.
//
// BEHAVIOUR
// - All state changes happen on the rising edge of clk only; there are no
//   asynchronous paths.
// - Priority at each edge:
//   - resetn=1 -> out <= RESET_VAL
//   - else load=1 -> out <= in
//   - else ud=1 -> out <= out + 1
//   - else -> out <= out - 1
// - The counter counts on every non-reset, non-load cycle; there is no hold
//   state.
// - Latency:
//   - load, reset and count each take effect on the edge where they are
//     sampled.
//   - out shows the new value after that edge (one-cycle latency).
// - Arithmetic is modulo 2^WIDTH:
//   - up from all-ones wraps to 0;
//   - down from 0 wraps to all-ones;
//   - no carry/borrow output, no saturation.
// - Simultaneous events:
//   - reset overrides load and ud;
//   - load overrides ud, so ud is ignored while load=1.
// - Reset mid-operation: a held reset pins out to RESET_VAL every cycle.
//   Counting resumes from RESET_VAL on the first edge after resetn falls.
// - Unknown inputs:
//   - ud and in are don't-care while reset or load, respectively, is
//     asserted.
//   - No X-suppression logic is required.
// - Power-up: out is undefined until the first reset or load edge. The
//   integrator must apply one of them before relying on out.
// - No combinational path from any input to out.
//
// STRUCTURE
// - Shared package (udc_pkg):
//   - UDC_WIDTH_DEFAULT = 8;
//   - typedef for the count vector (logic [WIDTH-1:0]);
//   - localparams UP = 1'b1, DOWN = 1'b0.
// - Optional sub-module udc_next: a purely combinational next-state selector.
//   - inputs: cur, in, load, ud, rst; output: nxt;
//   - implements the priority mux and the +/-1 adder.
// - The top level holds only the WIDTH-bit register clocked by clk.
//
// TESTING
// - Reset:
//   - resetn=1 for 2 edges with load=1, in=8'h55 -> out==8'h00 after the
//     first edge;
//   - out stays 8'h00 while resetn=1.
// - Load:
//   - resetn=0, in=8'hAA, load=1 for 1 edge -> out==8'hAA;
//   - out is unchanged by ud during that edge.
// - Count up:
//   - from 8'hAA, load=0, ud=1 for 5 edges -> out==8'hAF, stepping +1 each
//     edge.
// - Count down with wrap:
//   - load 8'h01, then ud=0 for 3 edges -> 8'h00, 8'hFF, 8'hFE.
// - Count up with wrap:
//   - load 8'hFE, then ud=1 for 3 edges -> 8'hFF, 8'h00, 8'h01.
// - Priority:
//   - assert load=1, in=8'h3C, ud=1 with resetn=1 -> 8'h00;
//   - next edge with resetn=0 -> 8'h3C;
//   - then release load, ud=0 -> 8'h3B.

Source files
------------

// File: rtl/udc_pkg.sv
// Shared types and constants for the loadable up/down counter.
// Provides the default width, count vector type and direction codes.
package udc_pkg;

    localparam int UDC_WIDTH_DEFAULT = 8;

    typedef logic [UDC_WIDTH_DEFAULT-1:0] udc_cnt_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/udc_next.sv
// Combinational next-count selector: reset > load > count up/down.
// Ports: cur (current count), in (preset), load, ud, rst -> nxt.
module udc_next
    import udc_pkg::*;
#(
    parameter int               WIDTH     = UDC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             ud,
    input  logic             rst,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        nxt = cur;
        if (rst) begin
            nxt = RESET_VAL;
        end else if (load) begin
            nxt = in;
        end else if (ud == UP) begin
            // modulo 2^WIDTH: wraps naturally at the vector width
            nxt = cur + ONE;
        end else begin
            nxt = cur - ONE;
        end
    end

endmodule

// File: rtl/udc_8bit.sv
// Loadable synchronous up/down counter with a fully registered output.
// Ports: clk, resetn (sync, active-high), in, load, ud -> out.
module udc_8bit
    import udc_pkg::*;
#(
    parameter int               WIDTH     = UDC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             ud,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    udc_next #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) u_next (
        .cur (out_q),
        .in  (in),
        .load(load),
        .ud  (ud),
        .rst (resetn),
        .nxt (out_d)
    );

    // resetn is active-high despite its name
    always_ff @(posedge clk) begin
        if (resetn) begin
            out_q <= RESET_VAL;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_udc_8bit.sv
// Self-checking bench for udc_8bit against an arithmetic reference model.
// Directed scenarios followed by randomized reset/load/count traffic.
module tb_udc_8bit;

    logic       clk;
    logic       resetn;
    logic [7:0] in;
    logic       load;
    logic       ud;
    logic [7:0] out;

    int n_cmp;
    int n_bad;
    int model;

    udc_8bit dut (
        .clk   (clk),
        .resetn(resetn),
        .in    (in),
        .load  (load),
        .ud    (ud),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge from the current inputs, then let
    // the DUT take the same edge and settle before the caller samples.
    task automatic tick();
        if (resetn)
            model = 0;
        else if (load)
            model = int'(in);
        else if (ud)
            model = (model + 1) % 256;
        else
            model = (model + 255) % 256;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; load = 1'b1; in = 8'h55; ud = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out !== 8'h00) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h want 00", i, out);
            end
        end
    endtask

    task automatic test_load();
        resetn = 1'b0; load = 1'b1; in = 8'hAA; ud = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'hAA) begin
            n_bad++;
            $display("FAIL load: got %h want aa", out);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] want;
        load = 1'b0; ud = 1'b1;
        want = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            want = want + 8'd1;
            n_cmp++;
            if (out !== want) begin
                n_bad++;
                $display("FAIL count_up[%0d]: got %h want %h", i, out, want);
            end
        end
        n_cmp++;
        if (out !== 8'hAF) begin
            n_bad++;
            $display("FAIL count_up_end: got %h want af", out);
        end
    endtask

    task automatic test_wrap(input logic [7:0] start, input logic dir,
                             input logic [23:0] exp3, input string nm);
        logic [7:0] want;
        resetn = 1'b0; load = 1'b1; in = start; ud = ~dir;
        tick();
        n_cmp++;
        if (out !== start) begin
            n_bad++;
            $display("FAIL %s_load: got %h want %h", nm, out, start);
        end
        load = 1'b0; ud = dir; in = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            want = exp3[23 - 8*i -: 8];
            n_cmp++;
            if (out !== want) begin
                n_bad++;
                $display("FAIL %s[%0d]: got %h want %h", nm, i, out, want);
            end
        end
    endtask

    task automatic test_priority();
        resetn = 1'b1; load = 1'b1; in = 8'h3C; ud = 1'b1;
        tick();
        n_cmp++;
        if (out !== 8'h00) begin
            n_bad++;
            $display("FAIL prio_reset: got %h want 00", out);
        end
        resetn = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'h3C) begin
            n_bad++;
            $display("FAIL prio_load: got %h want 3c", out);
        end
        load = 1'b0; ud = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'h3B) begin
            n_bad++;
            $display("FAIL prio_down: got %h want 3b", out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 19) == 0);
            load   = ($urandom_range(0, 5) == 0);
            ud     = 1'($urandom);
            in     = 8'($urandom);
            tick();
            n_cmp++;
            if (int'(out) !== model) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, out,
                         model[7:0]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model = 0;
        resetn = 1'b0; load = 1'b0; ud = 1'b0; in = 8'h00;
        @(negedge clk);
        test_reset();
        test_load();
        test_count_up();
        test_wrap(8'h01, 1'b0, 24'h00FFFE, "wrap_down");
        test_wrap(8'hFE, 1'b1, 24'hFF0001, "wrap_up");
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
